// File: rtl/lfsr_arbiter_pkg.sv
// Shared types and defaults for the LFSR arbiter: FSM state encoding,
// default parameter values and width helpers.
package lfsr_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_WAIT_RDY,
        ST_WARMUP,
        ST_IDLE,
        ST_STEP,
        ST_GRANT,
        ST_ERROR
    } state_e;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_NREQ          = 4;
    localparam int DEF_RST_CYCLES    = 2;
    localparam int DEF_WARMUP        = 4;
    localparam int DEF_READY_TIMEOUT = 16;

    function automatic int ptr_w(input int nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

    // One shared counter serves the reset, warm-up and timeout phases.
    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lfsr_arbiter_if.sv
// Requester-side bus of the LFSR arbiter: level requests in, one-hot grant
// with the delivered random value out.
interface lfsr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] rnd;
    logic             rnd_valid;

    modport master (
        output req,
        input  gnt,
        input  rnd,
        input  rnd_valid
    );

    modport slave (
        input  req,
        output gnt,
        output rnd,
        output rnd_valid
    );
endinterface

// File: rtl/lfsr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ.
module rr_pick
    import lfsr_arbiter_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int PW   = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [PW-1:0]   win_idx
);

    logic [PW:0] cand;
    logic        found;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            // One extra bit keeps ptr+i exact before folding back into range.
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!found && req[cand[PW-1:0]]) begin
                found                  = 1'b1;
                win_idx                = cand[PW-1:0];
                win_oh[cand[PW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lfsr_arbiter.sv
// Owns one LFSR instance: brings it out of reset, discards warm-up states,
// then hands out one fresh LFSR step per round-robin grant.
module lfsr_arbiter
    import lfsr_arbiter_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int NREQ          = DEF_NREQ,
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int WARMUP        = DEF_WARMUP,
    parameter int READY_TIMEOUT = DEF_READY_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    lfsr_arbiter_if.slave    bus,
    input  logic             reseed,
    output logic             busy,
    output logic             err_timeout,
    output logic             lfsr_reset,
    output logic             lfsr_enable,
    input  logic             lfsr_ready,
    input  logic [WIDTH-1:0] lfsr_value
);

    localparam int PW = ptr_w(NREQ);
    localparam int CW = cnt_w(RST_CYCLES, WARMUP, READY_TIMEOUT);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    win_idx_q, win_idx_d;
    logic [NREQ-1:0]  win_oh_q, win_oh_d;
    logic             pend_q, pend_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] rnd_q, rnd_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             lrst_q, lrst_d;
    logic             len_q, len_d;

    logic [NREQ-1:0]  pick_oh;
    logic [PW-1:0]    pick_idx;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        win_oh_d  = win_oh_q;
        pend_d    = pend_q;
        gnt_d     = '0;
        rnd_d     = rnd_q;
        vld_d     = 1'b0;
        err_d     = err_q;
        lrst_d    = lrst_q;
        len_d     = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                if (reseed) begin
                    cnt_d  = '0;
                    lrst_d = 1'b1;
                end else if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    lrst_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_WAIT_RDY;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_RDY: begin
                if (reseed) begin
                    cnt_d   = '0;
                    lrst_d  = 1'b1;
                    state_d = ST_INIT;
                end else if (lfsr_ready) begin
                    cnt_d = '0;
                    if (WARMUP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        len_d   = 1'b1;
                        state_d = ST_WARMUP;
                    end
                end else if (cnt_q == CW'(READY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WARMUP: begin
                // Enable is already high for the current step; cnt counts steps issued.
                if (reseed) begin
                    cnt_d   = '0;
                    lrst_d  = 1'b1;
                    state_d = ST_INIT;
                end else if (cnt_q == CW'(WARMUP - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    len_d = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE: begin
                if (reseed || pend_q) begin
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                    lrst_d  = 1'b1;
                    state_d = ST_INIT;
                end else if (|bus.req) begin
                    win_idx_d = pick_idx;
                    win_oh_d  = pick_oh;
                    len_d     = 1'b1;
                    state_d   = ST_STEP;
                end
            end
            ST_STEP: begin
                if (reseed) pend_d = 1'b1;
                state_d = ST_GRANT;
            end
            ST_GRANT: begin
                // lfsr_value already reflects the step taken on the STEP edge.
                if (reseed) pend_d = 1'b1;
                gnt_d   = win_oh_q;
                rnd_d   = lfsr_value;
                vld_d   = 1'b1;
                ptr_d   = (win_idx_q == PW'(NREQ - 1)) ? '0 : win_idx_q + PW'(1);
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (reseed) begin
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    lrst_d  = 1'b1;
                    state_d = ST_INIT;
                end
            end
            default: begin
                cnt_d   = '0;
                lrst_d  = 1'b1;
                state_d = ST_INIT;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            ptr_q     <= '0;
            win_idx_q <= '0;
            win_oh_q  <= '0;
            pend_q    <= 1'b0;
            gnt_q     <= '0;
            rnd_q     <= '0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            lrst_q    <= 1'b1;
            len_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            win_idx_q <= win_idx_d;
            win_oh_q  <= win_oh_d;
            pend_q    <= pend_d;
            gnt_q     <= gnt_d;
            rnd_q     <= rnd_d;
            vld_q     <= vld_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            lrst_q    <= lrst_d;
            len_q     <= len_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rnd       = rnd_q;
    assign bus.rnd_valid = vld_q;
    assign busy          = busy_q;
    assign err_timeout   = err_q;
    assign lfsr_reset    = lrst_q;
    assign lfsr_enable   = len_q;

endmodule
